// File: rtl/player_mover.sv
// player_mover: per-request player pose update from key levels, with axis-separated
// grid collision so a blocked diagonal move slides along the wall.
module player_mover #(
  parameter int X_W         = 14,
  parameter int Y_W         = 13,
  parameter int ANG_W       = 8,
  parameter int DIR_W       = 10,
  parameter int TURN_STEP   = 2,
  parameter int CELL_SHIFT  = 8,
  parameter int GX_W        = X_W - CELL_SHIFT,
  parameter int GY_W        = Y_W - CELL_SHIFT,
  parameter int GRID_LAT    = 1,
  parameter int TICK_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             moved,
  input  logic             turn_right,
  input  logic             turn_left,
  input  logic             move_forward,
  input  logic             move_backward,
  input  logic             strafe_right,
  input  logic             strafe_left,
  input  logic [X_W-1:0]   cur_pos_x,
  input  logic [Y_W-1:0]   cur_pos_y,
  input  logic [ANG_W-1:0] cur_angle,
  input  logic [DIR_W-1:0] dir_x,
  input  logic [DIR_W-1:0] dir_y,
  output logic [X_W-1:0]   next_pos_x,
  output logic [Y_W-1:0]   next_pos_y,
  output logic [ANG_W-1:0] next_angle,
  output logic [GX_W-1:0]  grid_x,
  output logic [GY_W-1:0]  grid_y,
  input  logic [2:0]       grid_out
);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = $clog2(GRID_LAT + 1);
  typedef enum logic [2:0] {IDLE, CALC, PROBE_XY, PROBE_X, PROBE_Y, COMMIT, DONE} state_t;
  state_t state, state_d;
  logic [TW-1:0] tick;
  logic [WW-1:0] wcnt;
  logic signed [X_W+1:0] dxx, dyx, fx_c, cx_c, cand_x;
  logic signed [Y_W+1:0] dxy, dyy, fy_c, cy_c, cand_y;
  logic [ANG_W-1:0] ca_c, cand_a;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic fwd, bwd, sr, sl, tr, tl, vx_c, vy_c, vx, vy, fx_nz, fy_nz, x_ok, y_ok, xy_ok;
  logic use_x, use_y, wait_done, hit, ld_xy, ld_x, ld_y, moved_c;
  assign fwd = move_forward & ~move_backward;
  assign bwd = move_backward & ~move_forward;
  assign sr  = strafe_right & ~strafe_left;
  assign sl  = strafe_left & ~strafe_right;
  assign tr  = turn_right & ~turn_left;
  assign tl  = turn_left & ~turn_right;
  assign dxx = {{(X_W+2-DIR_W){dir_x[DIR_W-1]}}, dir_x};
  assign dyx = {{(X_W+2-DIR_W){dir_y[DIR_W-1]}}, dir_y};
  assign dxy = {{(Y_W+2-DIR_W){dir_x[DIR_W-1]}}, dir_x};
  assign dyy = {{(Y_W+2-DIR_W){dir_y[DIR_W-1]}}, dir_y};
  // strafing right is the step vector rotated a quarter turn: (-dy, +dx)
  assign fx_c = (fwd ? dxx : bwd ? -dxx : '0) + (sr ? -dyx : sl ? dyx : '0);
  assign fy_c = (fwd ? dyy : bwd ? -dyy : '0) + (sr ? dxy : sl ? -dxy : '0);
  assign cx_c = {2'b00, cur_pos_x} + fx_c;
  assign cy_c = {2'b00, cur_pos_y} + fy_c;
  assign ca_c = tr ? cur_angle + ANG_W'(TURN_STEP) : tl ? cur_angle - ANG_W'(TURN_STEP) : cur_angle;
  assign vx_c = cx_c[X_W+1:X_W] == 2'b00;
  assign vy_c = cy_c[Y_W+1:Y_W] == 2'b00;
  assign vx = cand_x[X_W+1:X_W] == 2'b00;
  assign vy = cand_y[Y_W+1:Y_W] == 2'b00;
  assign xy_ok = vx & vy;
  assign x_ok = fx_nz & vx;
  assign y_ok = fy_nz & vy;
  assign wait_done = wcnt == WW'(GRID_LAT);
  assign hit = wait_done & (grid_out == 3'd0);
  assign nx = use_x ? cand_x[X_W-1:0] : cur_pos_x;
  assign ny = use_y ? cand_y[Y_W-1:0] : cur_pos_y;
  assign moved_c = nx != cur_pos_x || ny != cur_pos_y || cand_a != cur_angle;
  // the probe address is registered on the edge that enters the probing state
  assign ld_xy = state == CALC && state_d == PROBE_XY && vx_c && vy_c;
  assign ld_x = state != PROBE_X && state_d == PROBE_X && x_ok;
  assign ld_y = state != PROBE_Y && state_d == PROBE_Y && y_ok;
  always_comb begin
    state_d = state;
    done = state == DONE;
    case (state)
      IDLE:     state_d = start ? CALC : IDLE;
      CALC:     state_d = tick != '0 ? DONE : (fx_c == '0 && fy_c == '0) ? COMMIT : PROBE_XY;
      PROBE_XY: state_d = !xy_ok ? PROBE_X : !wait_done ? PROBE_XY : hit ? COMMIT : PROBE_X;
      PROBE_X:  state_d = !x_ok ? PROBE_Y : !wait_done ? PROBE_X : hit ? COMMIT : PROBE_Y;
      PROBE_Y:  state_d = (!y_ok || wait_done) ? COMMIT : PROBE_Y;
      COMMIT:   state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tick <= '0;
      wcnt <= '0;
      cand_x <= '0;
      cand_y <= '0;
      cand_a <= '0;
      fx_nz <= 1'b0;
      fy_nz <= 1'b0;
      use_x <= 1'b0;
      use_y <= 1'b0;
      moved <= 1'b0;
      next_pos_x <= '0;
      next_pos_y <= '0;
      next_angle <= '0;
      grid_x <= '0;
      grid_y <= '0;
    end else begin
      wcnt <= state_d != state ? '0 : wcnt + 1'b1;
      tick <= (state == COMMIT && moved_c) ? TW'(TICK_CYCLES - 1) : tick != '0 ? tick - 1'b1 : tick;
      if (state == CALC) begin
        cand_x <= cx_c;
        cand_y <= cy_c;
        cand_a <= ca_c;
        fx_nz <= fx_c != '0;
        fy_nz <= fy_c != '0;
        moved <= 1'b0;
      end
      use_x <= state == CALC ? 1'b0 : ((state == PROBE_XY && xy_ok) || (state == PROBE_X && x_ok)) && hit ? 1'b1 : use_x;
      use_y <= state == CALC ? 1'b0 : ((state == PROBE_XY && xy_ok) || (state == PROBE_Y && y_ok)) && hit ? 1'b1 : use_y;
      grid_x <= ld_xy ? cx_c[CELL_SHIFT +: GX_W] : ld_x ? cand_x[CELL_SHIFT +: GX_W] : ld_y ? cur_pos_x[CELL_SHIFT +: GX_W] : grid_x;
      grid_y <= ld_xy ? cy_c[CELL_SHIFT +: GY_W] : ld_x ? cur_pos_y[CELL_SHIFT +: GY_W] : ld_y ? cand_y[CELL_SHIFT +: GY_W] : grid_y;
      if (state == COMMIT) begin
        next_pos_x <= nx;
        next_pos_y <= ny;
        next_angle <= cand_a;
        moved <= moved_c;
      end
    end
endmodule

// File: tb/tb_player_mover.sv
// tb_player_mover: directed and randomized requests checked against a behavioural
// pose/collision/latency model kept in the bench.
module tb_player_mover;
  localparam int X_W = 14, Y_W = 13, ANG_W = 8, DIR_W = 10, GX_W = 6, GY_W = 5, TICK = 16;
  logic clock = 0, reset = 0, start = 0;
  logic turn_right = 0, turn_left = 0, move_forward = 0, move_backward = 0, strafe_right = 0, strafe_left = 0;
  logic [X_W-1:0] cur_pos_x = 0;
  logic [Y_W-1:0] cur_pos_y = 0;
  logic [ANG_W-1:0] cur_angle = 0;
  logic [DIR_W-1:0] dir_x = 0, dir_y = 0;
  logic [2:0] grid_out = 0;
  logic done, moved;
  logic [X_W-1:0] next_pos_x;
  logic [Y_W-1:0] next_pos_y;
  logic [ANG_W-1:0] next_angle;
  logic [GX_W-1:0] grid_x;
  logic [GY_W-1:0] grid_y;
  logic [2:0] map_m [64][32];
  int cyc = 0, n_chk = 0, n_pass = 0;
  bit active = 0, chk_en = 0;
  int c0 = 0, exp_l = 0, lat = 0, last_tc = -1000;
  logic [X_W-1:0] ex = 0, rx = 0;
  logic [Y_W-1:0] ey = 0, ry = 0;
  logic [ANG_W-1:0] ea = 0, ra = 0;
  logic [GX_W-1:0] egx = 0, rgx = 0;
  logic [GY_W-1:0] egy = 0, rgy = 0;
  bit rmoved = 0;

  player_mover #(.GRID_LAT(1), .TICK_CYCLES(TICK)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .moved(moved),
    .turn_right(turn_right), .turn_left(turn_left), .move_forward(move_forward),
    .move_backward(move_backward), .strafe_right(strafe_right), .strafe_left(strafe_left),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .dir_x(dir_x), .dir_y(dir_y), .next_pos_x(next_pos_x), .next_pos_y(next_pos_y),
    .next_angle(next_angle), .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out)
  );

  always #5 clock = ~clock;

  // map memory with one cycle of read latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
    grid_out <= map_m[grid_x][grid_y];
  end

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clock) if (chk_en) begin
    bit ed;
    ed = active && cyc == c0 + exp_l - 1;
    check("done", done, ed);
    if (ed) begin
      check("moved", moved, rmoved);
      check("next_x", next_pos_x, rx);
      check("next_y", next_pos_y, ry);
      check("next_a", next_angle, ra);
      check("grid_x", grid_x, rgx);
      check("grid_y", grid_y, rgy);
    end else if (!active) begin
      check("hold_x", next_pos_x, ex);
      check("hold_y", next_pos_y, ey);
      check("hold_a", next_angle, ea);
    end
  end

  // outcome of one request from the current inputs, map and time since last move
  task automatic predict();
    int dx, dy, fx, fy, cx, cy, p;
    bit fw, bw, sr, sl, tx, ty, vx, vy;
    dx = $signed(dir_x);
    dy = $signed(dir_y);
    fw = move_forward && !move_backward;
    bw = move_backward && !move_forward;
    sr = strafe_right && !strafe_left;
    sl = strafe_left && !strafe_right;
    c0 = cyc + 1;
    rgx = egx;
    rgy = egy;
    if (c0 - last_tc < TICK - 1) begin
      exp_l = 2; rx = ex; ry = ey; ra = ea; rmoved = 0;
      return;
    end
    fx = (fw ? dx : bw ? -dx : 0) + (sr ? -dy : sl ? dy : 0);
    fy = (fw ? dy : bw ? -dy : 0) + (sr ? dx : sl ? -dx : 0);
    ra = ANG_W'(int'(cur_angle) + ((turn_right && !turn_left) ? 2 : (turn_left && !turn_right) ? -2 : 0));
    cx = int'(cur_pos_x) + fx;
    cy = int'(cur_pos_y) + fy;
    vx = cx >= 0 && cx < 2 ** X_W;
    vy = cy >= 0 && cy < 2 ** Y_W;
    tx = 0; ty = 0; p = 0;
    if (fx != 0 || fy != 0) begin
      if (vx && vy) begin
        p += 2; rgx = GX_W'(cx >> 8); rgy = GY_W'(cy >> 8);
        if (map_m[cx >> 8][cy >> 8] == 0) begin tx = 1; ty = 1; end
      end else p += 1;
      if (!tx) begin
        if (fx != 0 && vx) begin
          p += 2; rgx = GX_W'(cx >> 8); rgy = GY_W'(int'(cur_pos_y) >> 8);
          if (map_m[cx >> 8][int'(cur_pos_y) >> 8] == 0) tx = 1;
        end else p += 1;
        if (!tx) begin
          if (fy != 0 && vy) begin
            p += 2; rgx = GX_W'(int'(cur_pos_x) >> 8); rgy = GY_W'(cy >> 8);
            if (map_m[int'(cur_pos_x) >> 8][cy >> 8] == 0) ty = 1;
          end else p += 1;
        end
      end
    end
    exp_l = 3 + p;
    rx = tx ? X_W'(cx) : cur_pos_x;
    ry = ty ? Y_W'(cy) : cur_pos_y;
    rmoved = rx != cur_pos_x || ry != cur_pos_y || ra != cur_angle;
  endtask

  task automatic set_in(input logic [5:0] k, input int x, input int y, input int a, input int dx, input int dy);
    {move_forward, move_backward, strafe_right, strafe_left, turn_right, turn_left} = k;
    cur_pos_x = X_W'(x);
    cur_pos_y = Y_W'(y);
    cur_angle = ANG_W'(a);
    dir_x = DIR_W'(dx);
    dir_y = DIR_W'(dy);
  endtask

  task automatic run_req(input int gap);
    repeat (gap + 1) @(negedge clock);
    predict();
    start = 1;
    active = 1;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clock);
    lat = cyc - c0 + 1;
    if (!done) check("done_timeout", 0, 1);
    @(posedge clock);
    #1;
    active = 0;
    if (rmoved) last_tc = c0 + exp_l - 1;
    ex = rx; ey = ry; ea = ra; egx = rgx; egy = rgy;
  endtask

  task automatic pin(input string n, input int lt, input bit mv, input int x, input int y, input int a);
    check({n, "_lat"}, lat, lt);
    check({n, "_moved"}, moved, mv);
    check({n, "_x"}, next_pos_x, x);
    check({n, "_y"}, next_pos_y, y);
    check({n, "_a"}, next_angle, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) for (int j = 0; j < 32; j++) map_m[i][j] = 0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_done", done, 0);
    check("rst_moved", moved, 0);
    check("rst_x", next_pos_x, 0);
    check("rst_y", next_pos_y, 0);
    check("rst_a", next_angle, 0);
    check("rst_gx", grid_x, 0);
    check("rst_gy", grid_y, 0);
    #1 reset = 1;
    chk_en = 1;
    // plain forward step into an empty cell
    set_in(6'b100000, 'h1000, 'h0800, 0, 16, 0);
    run_req(2);
    pin("fwd", 5, 1, 'h1010, 'h0800, 0);
    check("fwd_gx", grid_x, 'h10);
    check("fwd_gy", grid_y, 'h08);
    // turn-only wraps below zero, no probe
    set_in(6'b000001, 'h1010, 'h0800, 1, 16, 0);
    run_req(14);
    pin("turn", 3, 1, 'h1010, 'h0800, 255);
    check("turn_gx", grid_x, 'h10);
    // diagonal blocked, slide along x
    map_m['h11]['h09] = 1;
    set_in(6'b101000, 'h10F8, 'h08F8, 0, 16, 0);
    run_req(14);
    pin("slide", 7, 1, 'h1108, 'h08F8, 0);
    check("slide_gx", grid_x, 'h11);
    check("slide_gy", grid_y, 'h08);
    // all probes blocked, turn still applied
    map_m['h11]['h08] = 2;
    map_m['h10]['h09] = 3;
    set_in(6'b101010, 'h10F8, 'h08F8, 0, 16, 0);
    run_req(14);
    pin("block", 9, 1, 'h10F8, 'h08F8, 2);
    check("block_gx", grid_x, 'h10);
    check("block_gy", grid_y, 'h09);
    // rate limit: too soon, then late enough
    set_in(6'b100000, 'h1000, 'h0800, 0, 16, 0);
    run_req(3);
    pin("busy", 2, 0, 'h10F8, 'h08F8, 2);
    run_req(14);
    pin("late", 5, 1, 'h1010, 'h0800, 0);
    // backward past x=0: every probe skipped
    set_in(6'b010000, 5, 'h0800, 0, 16, 0);
    run_req(14);
    pin("edge", 6, 0, 5, 'h0800, 0);
    check("edge_gx", grid_x, 'h10);
    // same request aborted by reset while in the x-only probe
    @(negedge clock);
    c0 = cyc + 1;
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    #2;
    ex = 0; ey = 0; ea = 0; egx = 0; egy = 0; last_tc = -1000;
    reset = 0;
    #1;
    check("abort_done", done, 0);
    check("abort_x", next_pos_x, 0);
    check("abort_gx", grid_x, 0);
    check("abort_gy", grid_y, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1;
    // randomized requests over a random map
    for (int i = 0; i < 64; i++) for (int j = 0; j < 32; j++)
      map_m[i][j] = $urandom_range(0, 99) < 35 ? 3'($urandom_range(1, 7)) : 3'd0;
    for (int n = 0; n < 200; n++) begin
      int x, y, dx, dy;
      x = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? int'($urandom_range(0, 300)) : 16383 - int'($urandom_range(0, 300))) : int'($urandom_range(0, 16383));
      y = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? int'($urandom_range(0, 300)) : 8191 - int'($urandom_range(0, 300))) : int'($urandom_range(0, 8191));
      dx = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 1023)) - 512;
      dy = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 1023)) - 512;
      set_in(6'($urandom), x, y, int'($urandom_range(0, 255)), dx, dy);
      run_req(int'($urandom_range(0, 18)));
    end
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
